// File: rtl/painterengine_gpu_reader_scheduler_if.sv
// Bundle between the reader scheduler, its four requesters and the shared DMA reader.
// slave = scheduler side, master = requester/reader side.
interface painterengine_gpu_reader_scheduler_if;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] err;
    logic [2:0] err_type;
    logic       busy;
    logic [1:0] grant_index;
    logic [3:0] router;
    logic       reader_resetn;
    logic       reader_done;
    logic       reader_error;
    logic [2:0] reader_error_type;

    modport slave (
        input  req, reader_done, reader_error, reader_error_type,
        output ack, err, err_type, busy, grant_index, router, reader_resetn
    );

    modport master (
        output req, reader_done, reader_error, reader_error_type,
        input  ack, err, err_type, busy, grant_index, router, reader_resetn
    );
endinterface

// File: rtl/painterengine_gpu_reader_scheduler.sv
// Round-robin scheduler sharing one single-shot DMA reader between four channels.
// Each job is framed by a reader reset pulse, so the reader runs one job per release.
//
// state | meaning
// IDLE  | reader in reset, router 0, hold counter runs, arbitrate once hold met
// SETUP | router driven, reader still in reset for one cycle
// RUN   | reader released, wait for done/error level
// DONE  | ack/err pulse visible, reader back in reset, router still held
module painterengine_gpu_reader_scheduler #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                                   i_wire_clock,
    input  logic                                   i_wire_resetn,
    painterengine_gpu_reader_scheduler_if.slave    bus
);

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [1:0]       grant, grant_nx;
    logic [3:0]       router, router_nx;
    logic [3:0]       ack, ack_nx;
    logic [3:0]       err, err_nx;
    logic [2:0]       err_type, err_type_nx;
    logic             busy, busy_nx;
    logic             rd_resetn, rd_resetn_nx;

    logic             found;
    logic [1:0]       winner;
    logic [1:0]       scan;

    // First requesting channel after the last granted one, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        scan   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            scan = ptr + 2'(i);
            if (!found && bus.req[scan]) begin
                found  = 1'b1;
                winner = scan;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        ptr_nx       = ptr;
        grant_nx     = grant;
        router_nx    = router;
        ack_nx       = ack;
        err_nx       = err;
        err_type_nx  = err_type;
        busy_nx      = busy;
        rd_resetn_nx = rd_resetn;

        case (state)
            ST_IDLE: begin
                rd_resetn_nx = 1'b0;
                router_nx    = 4'b0000;
                if (hold_cnt < HOLD) begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end else if (found) begin
                    router_nx = 4'b0001 << winner;
                    grant_nx  = winner;
                    busy_nx   = 1'b1;
                    state_nx  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                rd_resetn_nx = 1'b1;
                state_nx     = ST_RUN;
            end
            ST_RUN: begin
                // Error wins when the reader raises both levels together.
                if (bus.reader_error) begin
                    err_nx       = 4'b0001 << grant;
                    err_type_nx  = bus.reader_error_type;
                    rd_resetn_nx = 1'b0;
                    state_nx     = ST_DONE;
                end else if (bus.reader_done) begin
                    ack_nx       = 4'b0001 << grant;
                    rd_resetn_nx = 1'b0;
                    state_nx     = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_nx      = grant;
                hold_cnt_nx = '0;
                router_nx   = 4'b0000;
                busy_nx     = 1'b0;
                ack_nx      = 4'b0000;
                err_nx      = 4'b0000;
                state_nx    = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            ptr       <= 2'd3;
            grant     <= 2'd0;
            router    <= 4'b0000;
            ack       <= 4'b0000;
            err       <= 4'b0000;
            err_type  <= 3'b000;
            busy      <= 1'b0;
            rd_resetn <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            ptr       <= ptr_nx;
            grant     <= grant_nx;
            router    <= router_nx;
            ack       <= ack_nx;
            err       <= err_nx;
            err_type  <= err_type_nx;
            busy      <= busy_nx;
            rd_resetn <= rd_resetn_nx;
        end
    end

    assign bus.router        = router;
    assign bus.reader_resetn = rd_resetn;
    assign bus.ack           = ack;
    assign bus.err           = err;
    assign bus.err_type      = err_type;
    assign bus.busy          = busy;
    assign bus.grant_index   = grant;

endmodule
